ball_engine: RTL

Parametrised ball motion and rendering engine for the brick-breaker game.
- Moves a BALL_SIZE×BALL_SIZE square across the SCREEN_W×SCREEN_H frame buffer.
- Reflects off the three play-field walls and off external collision reports from the paddle and brick logic.
- Emits an erase/draw pixel stream to the vga_adapter.
- Sits between the game-state controller, which drives launch/halt, and the VGA pixel arbiter.

---
 rtl/bb_pkg.sv | 20 ++
 rtl/tick_divider.sv | 27 ++
 rtl/ball_engine.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bb_pkg.sv
// Shared brick-breaker definitions: FSM state codes, colour constants and
// direction encoding used by the ball engine.
package bb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_SERVE_DRAW = 3'd1;
  localparam state_t S_WAIT_TICK  = 3'd2;
  localparam state_t S_ERASE      = 3'd3;
  localparam state_t S_UPDATE     = 3'd4;
  localparam state_t S_DRAW       = 3'd5;

  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/tick_divider.sv
// Free-running motion tick generator: one-cycle tick every TICK_DIV clocks.
module tick_divider #(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == CW'(TICK_DIV - 1)) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Ball motion and erase/draw pixel engine for the brick-breaker game.
// Optional feature: define BALL_SPEEDUP_EN to raise speed every SPEEDUP_HITS paddle hits.
import bb_pkg::*;

module ball_engine #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter int unsigned BALL_SIZE    = 2,
  parameter int unsigned VEL_W        = 3,
  parameter int unsigned TICK_DIV     = 833333,
  parameter int unsigned SERVE_X      = 20,
  parameter int unsigned SERVE_Y      = 20,
  parameter logic [2:0]  BALL_COLOUR  = COLOUR_WHITE,
  parameter logic [2:0]  BG_COLOUR    = COLOUR_BLACK,
  parameter int unsigned SPEEDUP_HITS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        launch,
  input  logic                        halt,
  input  logic                        hit_x,
  input  logic                        hit_y,
  input  logic                        paddle_hit,
  output logic [$clog2(SCREEN_W)-1:0] ball_x,
  output logic [$clog2(SCREEN_H)-1:0] ball_y,
  output logic [$clog2(SCREEN_W)-1:0] pix_x,
  output logic [$clog2(SCREEN_H)-1:0] pix_y,
  output logic [2:0]                  pix_colour,
  output logic                        plot,
  output logic                        frame_done,
  output logic                        lost,
  output logic                        busy
);

  localparam int unsigned XW = $clog2(SCREEN_W);
  localparam int unsigned YW = $clog2(SCREEN_H);
  localparam logic [XW:0] X_MAX = (XW+1)'(SCREEN_W - BALL_SIZE);
  localparam logic [YW:0] Y_MAX = (YW+1)'(SCREEN_H - BALL_SIZE);
  localparam logic [2:0]  LAST  = 3'(BALL_SIZE - 1);

  state_t           state;
  logic             tick, tick_pending, halt_pending, exit_flag;
  logic             hit_x_flag, hit_y_flag, dir_x, dir_y;
  logic [VEL_W-1:0] mag_x, mag_y;
  logic [2:0]       col, row, nxt_col, nxt_row;

  logic             eff_dx, eff_dy, new_dx, new_dy, out_bottom, sweep_end;
  logic [XW:0]      wx, mx_w, nx;
  logic [YW:0]      wy, my_w, ny;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

`ifdef BALL_SPEEDUP_EN
  localparam int unsigned HCW = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;
  logic [HCW-1:0] hit_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count <= '0;
      mag_x     <= VEL_W'(1);
      mag_y     <= VEL_W'(1);
    end else if (state == S_IDLE) begin
      hit_count <= '0;
      mag_x     <= VEL_W'(1);
      mag_y     <= VEL_W'(1);
    end else if (paddle_hit) begin
      if (hit_count == HCW'(SPEEDUP_HITS - 1)) begin
        hit_count <= '0;
        if (mag_x != '1) mag_x <= mag_x + VEL_W'(1);
        if (mag_y != '1) mag_y <= mag_y + VEL_W'(1);
      end else begin
        hit_count <= hit_count + HCW'(1);
      end
    end
  end
`else
  logic [1:0] unused_speedup;
  assign unused_speedup = {paddle_hit, 1'(SPEEDUP_HITS != 0)};
  assign mag_x = VEL_W'(1);
  assign mag_y = VEL_W'(1);
`endif

  // Sticky hits fold into the direction before the wall checks run.
  always_comb begin
    eff_dx = dir_x ^ hit_x_flag;
    eff_dy = dir_y ^ hit_y_flag;
    wx     = {1'b0, ball_x};
    wy     = {1'b0, ball_y};
    mx_w   = (XW+1)'(mag_x);
    my_w   = (YW+1)'(mag_y);
    new_dx = eff_dx;
    new_dy = eff_dy;
    out_bottom = 1'b0;
    if (eff_dx == DIR_NEG) begin
      if (wx < mx_w) begin
        nx = '0;
        new_dx = DIR_POS;
      end else begin
        nx = wx - mx_w;
      end
    end else if (wx + mx_w > X_MAX) begin
      nx = X_MAX;
      new_dx = DIR_NEG;
    end else begin
      nx = wx + mx_w;
    end
    if (eff_dy == DIR_NEG) begin
      if (wy < my_w) begin
        ny = '0;
        new_dy = DIR_POS;
      end else begin
        ny = wy - my_w;
      end
    end else if (wy + my_w > Y_MAX) begin
      ny = wy;
      out_bottom = 1'b1;
    end else begin
      ny = wy + my_w;
    end
    sweep_end = (col == LAST) && (row == LAST);
    if (col == LAST) begin
      nxt_col = '0;
      nxt_row = row + 3'd1;
    end else begin
      nxt_col = col + 3'd1;
      nxt_row = row;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      ball_x       <= XW'(SERVE_X);
      ball_y       <= YW'(SERVE_Y);
      dir_x        <= DIR_POS;
      dir_y        <= DIR_NEG;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_colour   <= BG_COLOUR;
      plot         <= 1'b0;
      frame_done   <= 1'b0;
      lost         <= 1'b0;
      busy         <= 1'b0;
      tick_pending <= 1'b0;
      halt_pending <= 1'b0;
      exit_flag    <= 1'b0;
      hit_x_flag   <= 1'b0;
      hit_y_flag   <= 1'b0;
      col          <= '0;
      row          <= '0;
    end else begin
      frame_done <= 1'b0;
      lost       <= 1'b0;
      if (state != S_IDLE) begin
        if (tick)  tick_pending <= 1'b1;
        if (hit_x) hit_x_flag   <= 1'b1;
        if (hit_y) hit_y_flag   <= 1'b1;
        if (halt && state != S_WAIT_TICK) halt_pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          tick_pending <= 1'b0;
          halt_pending <= 1'b0;
          exit_flag    <= 1'b0;
          hit_x_flag   <= 1'b0;
          hit_y_flag   <= 1'b0;
          if (launch) begin
            state      <= S_SERVE_DRAW;
            busy       <= 1'b1;
            plot       <= 1'b1;
            pix_x      <= ball_x;
            pix_y      <= ball_y;
            pix_colour <= BALL_COLOUR;
            col        <= '0;
            row        <= '0;
          end
        end
        S_WAIT_TICK: begin
          if (halt || halt_pending || tick_pending) begin
            state      <= S_ERASE;
            plot       <= 1'b1;
            pix_x      <= ball_x;
            pix_y      <= ball_y;
            pix_colour <= BG_COLOUR;
            col        <= '0;
            row        <= '0;
            if (halt || halt_pending) begin
              exit_flag    <= 1'b1;
              halt_pending <= 1'b0;
            end else begin
              tick_pending <= tick;
            end
          end
        end
        S_SERVE_DRAW, S_ERASE, S_DRAW: begin
          if (sweep_end) begin
            plot <= 1'b0;
            col  <= '0;
            row  <= '0;
            if (state == S_ERASE) begin
              if (exit_flag) begin
                state  <= S_IDLE;
                busy   <= 1'b0;
                ball_x <= XW'(SERVE_X);
                ball_y <= YW'(SERVE_Y);
                dir_x  <= DIR_POS;
                dir_y  <= DIR_NEG;
              end else begin
                state <= S_UPDATE;
              end
            end else begin
              state      <= S_WAIT_TICK;
              frame_done <= (state == S_DRAW);
            end
          end else begin
            col   <= nxt_col;
            row   <= nxt_row;
            pix_x <= ball_x + XW'(nxt_col);
            pix_y <= ball_y + YW'(nxt_row);
          end
        end
        S_UPDATE: begin
          // Hits landing this very cycle are kept for the next update.
          hit_x_flag <= hit_x;
          hit_y_flag <= hit_y;
          if (out_bottom) begin
            state  <= S_IDLE;
            lost   <= 1'b1;
            busy   <= 1'b0;
            ball_x <= XW'(SERVE_X);
            ball_y <= YW'(SERVE_Y);
            dir_x  <= DIR_POS;
            dir_y  <= DIR_NEG;
            hit_x_flag <= 1'b0;
            hit_y_flag <= 1'b0;
          end else begin
            state      <= S_DRAW;
            ball_x     <= nx[XW-1:0];
            ball_y     <= ny[YW-1:0];
            dir_x      <= new_dx;
            dir_y      <= new_dy;
            plot       <= 1'b1;
            pix_x      <= nx[XW-1:0];
            pix_y      <= ny[YW-1:0];
            pix_colour <= BALL_COLOUR;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule
